note_sequencer_ctrl: RTL and testbench

//  Sequencer that drives the 6-bit freq_select of the square-wave generator

---
 rtl/note_sequencer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_note_sequencer_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_ctrl.sv
// Note-table sequencer: steps through programmable {rest, note, dur} entries
// and drives freq_select/gate for the square-wave generator.
module note_sequencer_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7+DUR_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [5:0]        freq_select,
    output logic              gate,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GC_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int ENT_W = 7 + DUR_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [DUR_W-1:0]  dcnt_q, dcnt_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;
    logic [5:0]        freq_q, freq_d;
    logic              gate_q, gate_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_q;
    logic              tick, advance, seq_end;

    wire              rd_rest = rd_q[ENT_W-1];
    wire [5:0]        rd_note = rd_q[ENT_W-2 -: 6];
    wire [DUR_W-1:0]  rd_dur  = rd_q[DUR_W-1:0];

    assign tick = (pcnt_q == PC_W'(TICK_DIV - 1));

    // Read address follows the next-state address so the entry is ready in FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[addr_d];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        freq_d  = freq_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        advance = 1'b0;
        seq_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                gate_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                if (rd_dur == '0) begin
                    seq_end = 1'b1;
                end else begin
                    state_d = S_PLAY;
                    freq_d  = rd_note;
                    gate_d  = ~rd_rest;
                    dcnt_d  = rd_dur;
                    pcnt_d  = '0;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    dcnt_d = dcnt_q - 1'b1;
                    if (dcnt_q == DUR_W'(1)) begin
                        gate_d = 1'b0;
                        if (GAP_TICKS == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gcnt_d  = GC_W'(GAP_TICKS);
                            pcnt_d  = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    gcnt_d = gcnt_q - 1'b1;
                    if (gcnt_q == GC_W'(1))
                        advance = 1'b1;
                end
            end
            S_DONE: begin
                gate_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
                seq_end = 1'b1;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end

        if (seq_end) begin
            gate_d = 1'b0;
            if (loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        // Abort wins over any transition, including a same-cycle start.
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            gate_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pcnt_q  <= '0;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            freq_q  <= 6'd33;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pcnt_q  <= pcnt_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            freq_q  <= freq_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign freq_select = freq_q;
    assign gate        = gate_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cur_addr    = addr_q;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Directed bench: u0 has no inter-note gap, u2 has a 2-tick gap; both tick every 4 clocks.
module tb_note_sequencer_ctrl;

    logic        clk, reset_n, wr_en, start0, start2, stop, loop_en;
    logic [3:0]  wr_addr;
    logic [14:0] wr_data;
    logic [5:0]  f0, f2;
    logic        g0, b0, d0, g2, b2, d2;
    logic [3:0]  a0, a2;

    int n_chk = 0;
    int n_pass = 0;

    note_sequencer_ctrl #(.TICK_DIV(4), .DEPTH(16), .ADDR_W(4), .DUR_W(8), .GAP_TICKS(0)) u0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start0), .stop(stop), .loop_en(loop_en),
        .freq_select(f0), .gate(g0), .busy(b0), .done(d0), .cur_addr(a0));

    note_sequencer_ctrl #(.TICK_DIV(4), .DEPTH(16), .ADDR_W(4), .DUR_W(8), .GAP_TICKS(2)) u2 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start2), .stop(stop), .loop_en(loop_en),
        .freq_select(f2), .gate(g2), .busy(b2), .done(d2), .cur_addr(a2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, lp;
        logic       g, b, d;
        logic [5:0] f;
        logic [3:0] a;
    } vec_t;

    typedef struct {
        int         len;
        logic       g, d;
        logic [5:0] f;
    } seg_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic rest, input logic [5:0] note,
                      input logic [7:0] dur);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = {rest, note, dur};
        cyc();
        wr_en   = 1'b0;
    endtask

    vec_t vt[17];
    seg_t sg[11];
    logic [3:0] q[$];

    initial begin
        int bad, exp_a, dones, guard;
        logic seen;

        reset_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0;
        start0 = 0; start2 = 0; stop = 0; loop_en = 0;
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        chk("reset u0", {f0, g0, b0, d0, a0}, {6'd33, 1'b0, 1'b0, 1'b0, 4'd0});
        chk("reset u2", {f2, g2, b2, d2, a2}, {6'd33, 1'b0, 1'b0, 1'b0, 4'd0});

        // Single note, no gap: 12 cycles of gate, then done pulse.
        wr(4'd0, 1'b0, 6'd24, 8'd3);
        wr(4'd1, 1'b0, 6'd0, 8'd0);
        vt[0] = '{1, 0, 0, 0, 1, 0, 33, 0};
        for (int i = 1; i <= 12; i++) vt[i] = '{0, 0, 0, 1, 1, 0, 24, 0};
        vt[13] = '{0, 0, 0, 0, 1, 0, 24, 1};
        vt[14] = '{0, 0, 0, 0, 1, 1, 24, 1};
        vt[15] = '{0, 0, 0, 0, 0, 0, 24, 1};
        vt[16] = '{0, 0, 0, 0, 0, 0, 24, 1};
        for (int i = 0; i < 17; i++) begin
            start0 = vt[i].st; stop = vt[i].sp; loop_en = vt[i].lp;
            cyc();
            chk($sformatf("single vec%0d", i), {g0, b0, d0, f0, a0},
                {vt[i].g, vt[i].b, vt[i].d, vt[i].f, vt[i].a});
        end

        // Gap and rest on u2.
        wr(4'd0, 1'b0, 6'd33, 8'd2);
        wr(4'd1, 1'b1, 6'd12, 8'd1);
        wr(4'd2, 1'b0, 6'd45, 8'd1);
        wr(4'd3, 1'b0, 6'd0, 8'd0);
        sg[0]  = '{1, 0, 0, 33};  sg[1] = '{8, 1, 0, 33}; sg[2] = '{8, 0, 0, 33};
        sg[3]  = '{1, 0, 0, 33};  sg[4] = '{4, 0, 0, 12}; sg[5] = '{8, 0, 0, 12};
        sg[6]  = '{1, 0, 0, 12};  sg[7] = '{4, 1, 0, 45}; sg[8] = '{8, 0, 0, 45};
        sg[9]  = '{1, 0, 0, 45};  sg[10] = '{1, 0, 1, 45};
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (int s = 0; s < 11; s++) begin
            bad = 0;
            for (int c = 0; c < sg[s].len; c++) begin
                if ({g2, d2, f2} !== {sg[s].g, sg[s].d, sg[s].f}) bad++;
                cyc();
            end
            chk($sformatf("gap seg%0d bad cycles", s), bad, 0);
        end
        chk("gap end idle", {b2, d2, g2}, 3'b000);

        // Full table, no end marker: walks 0..15, done at 15, no wrap.
        for (int i = 0; i < 16; i++) wr(4'(i), 1'b0, 6'(i + 1), 8'd1);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        bad = 0; exp_a = 0; dones = 0; guard = 0;
        while (b0 && guard < 300) begin
            if (a0 == 4'(exp_a + 1)) exp_a++;
            else if (a0 != 4'(exp_a)) bad++;
            if (d0) begin
                dones++;
                if (a0 != 4'd15) bad++;
            end
            cyc();
            guard++;
        end
        chk("full walk timeout", guard < 300, 1);
        chk("full walk order", bad, 0);
        chk("full walk last addr", exp_a, 15);
        chk("full walk done count", dones, 1);
        chk("full walk freq hold", {f0, a0}, {6'd16, 4'd15});

        // Loop mode, then drop loop_en.
        wr(4'd0, 1'b0, 6'd5, 8'd1);
        wr(4'd1, 1'b0, 6'd6, 8'd1);
        wr(4'd2, 1'b0, 6'd0, 8'd0);
        loop_en = 1'b1;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        dones = 0;
        q.delete();
        for (int c = 0; c < 60; c++) begin
            if (d0) dones++;
            if (g0 && (q.size() == 0 || q[$] != a0)) q.push_back(a0);
            cyc();
        end
        bad = 0;
        foreach (q[i]) if (q[i] != 4'(i % 2)) bad++;
        chk("loop no done", dones, 0);
        chk("loop addr pattern", bad, 0);
        chk("loop enough notes", q.size() >= 8, 1);
        loop_en = 1'b0;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 40) begin
            cyc();
            seen = d0;
            guard++;
        end
        chk("loop drop done", seen, 1);
        cyc();
        chk("loop drop idle", b0, 0);

        // Stop mid-note on entry 1.
        wr(4'd0, 1'b0, 6'd7, 8'd1);
        wr(4'd1, 1'b0, 6'd8, 8'd3);
        wr(4'd2, 1'b0, 6'd0, 8'd0);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        guard = 0;
        while (!(g0 && a0 == 4'd1) && guard < 40) begin
            cyc();
            guard++;
        end
        chk("stop reach entry1", guard < 40, 1);
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop state", {b0, g0, d0, a0, f0}, {1'b0, 1'b0, 1'b0, 4'd1, 6'd8});
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (d0 || b0) dones++;
        end
        chk("stop no done", dones, 0);

        start0 = 1'b1; stop = 1'b1;
        cyc();
        start0 = 1'b0; stop = 1'b0;
        chk("start+stop idle", b0, 0);
        cyc();
        chk("start+stop still idle", b0, 0);

        // Write while busy must be dropped.
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        cyc();
        wr(4'd0, 1'b0, 6'd50, 8'd2);
        guard = 0;
        while (b0 && guard < 60) begin
            cyc();
            guard++;
        end
        chk("busy write idle", guard < 60, 1);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        guard = 0;
        while (!g0 && guard < 10) begin
            cyc();
            guard++;
        end
        chk("busy write readback", {g0, f0, a0}, {1'b1, 6'd7, 4'd0});

        // Async reset mid-note.
        repeat (2) cyc();
        chk("pre-reset playing", {g0, b0}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset", {f0, g0, b0, d0, a0}, {6'd33, 1'b0, 1'b0, 1'b0, 4'd0});
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("post reset idle", {f0, g0, b0}, {6'd33, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
